// File: rtl/seq_pkg.sv
// Shared types and defaults for the serializer slice.
// Build option: SEQ_SER_PARITY_EN adds the PARITY state.
package seq_pkg;

    localparam int DEF_WIDTH = 8;

`ifdef SEQ_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

endpackage

// File: rtl/seq_serializer_if.sv
// Parallel-in / serial-out handshake bundle of seq_serializer.
// master = word producer and line consumer, slave = serializer.
interface seq_serializer_if
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             idle_level;
    logic             ser_out;
    logic             bit_valid;
    logic             word_done;

    modport master (
        output data_in,
        output data_valid,
        output idle_level,
        input  data_ready,
        input  ser_out,
        input  bit_valid,
        input  word_done
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  idle_level,
        output data_ready,
        output ser_out,
        output bit_valid,
        output word_done
    );

endinterface

// File: rtl/seq_bitcnt.sv
// Bit position counter: loads 0, counts up, saturates at WIDTH-1.
module seq_bitcnt
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);

    assign tc = (count == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// MSB-first word serializer with gapless reload on the final bit.
// Build option: SEQ_SER_PARITY_EN appends an even-parity bit.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    seq_serializer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic             ser_q;
    logic             ser_nxt;
    logic             bv_q;
    logic             bv_nxt;
    logic             wd_q;
    logic             wd_nxt;
    logic [CW-1:0]    count;
    logic             tc;
    logic             inc;
    logic             last;
    logic             accept;

`ifdef SEQ_SER_PARITY_EN
    logic par;
    logic par_nxt;
    assign last = (state == PARITY);
`else
    assign last = (state == SHIFT) && tc;
`endif

    assign bus.data_ready = reset && ((state == IDLE) || last);
    assign accept         = bus.data_valid && bus.data_ready;
    assign inc            = (state == SHIFT) && !tc;

    assign bus.ser_out   = ser_q;
    assign bus.bit_valid = bv_q;
    assign bus.word_done = wd_q;

    seq_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .inc   (inc),
        .count (count),
        .tc    (tc)
    );

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        ser_nxt   = bus.idle_level;
        wd_nxt    = 1'b0;
`ifdef SEQ_SER_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            SHIFT: begin
                if (!tc) begin
                    sr_nxt  = sr << 1;
                    ser_nxt = sr[WIDTH-2];
`ifndef SEQ_SER_PARITY_EN
                    // entering the last data bit
                    wd_nxt  = (count == CW'(WIDTH - 2));
`endif
                end else begin
`ifdef SEQ_SER_PARITY_EN
                    state_nxt = PARITY;
                    ser_nxt   = par;
                    wd_nxt    = 1'b1;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef SEQ_SER_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // a new word overrides whatever the current word would do next
        if (accept) begin
            state_nxt = SHIFT;
            sr_nxt    = bus.data_in;
            ser_nxt   = bus.data_in[WIDTH-1];
            wd_nxt    = 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_nxt   = ^bus.data_in;
`endif
        end
        bv_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            sr    <= '0;
            ser_q <= 1'b0;
            bv_q  <= 1'b0;
            wd_q  <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            ser_q <= ser_nxt;
            bv_q  <= bv_nxt;
            wd_q  <= wd_nxt;
`ifdef SEQ_SER_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed cases plus random traffic
// against a queue-of-expected-bits model (SEQ_SER_PARITY_EN aware).
module tb_seq_serializer;

    localparam int W = 8;
`ifdef SEQ_SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic b;
        logic last;
    } ent_t;

    logic clock = 1'b0;
    logic reset;

    seq_serializer_if #(.WIDTH(W)) bus ();

    seq_serializer #(
        .WIDTH (W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    ent_t        q[$];
    logic        acc;
    logic [31:0] cap;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted word becomes its line bits, MSB first, plus parity.
    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            q.push_back(ent_t'{b: w[i], last: (i == 0) && !PAR});
        end
        if (PAR) q.push_back(ent_t'{b: ^w, last: 1'b1});
    endtask

    // One clock: check ready, advance model at the edge, check line.
    task automatic cyc();
        logic exp_ready;
        logic rst_edge;
        logic idl;
        logic es, ev, ew;
        ent_t d;
        #1;
        exp_ready = reset && (q.size() <= 1);
        chk("data_ready", 32'(bus.data_ready), 32'(exp_ready));
        @(posedge clock);
        rst_edge = !reset;
        idl      = bus.idle_level;
        acc      = 1'b0;
        if (rst_edge) begin
            q.delete();
        end else begin
            acc = bus.data_valid && exp_ready;
            if (q.size() > 0) d = q.pop_front();
            if (acc) push_word(bus.data_in);
        end
        #1;
        if (rst_edge) begin
            es = 1'b0; ev = 1'b0; ew = 1'b0;
        end else if (q.size() > 0) begin
            es = q[0].b; ev = 1'b1; ew = q[0].last;
        end else begin
            es = idl; ev = 1'b0; ew = 1'b0;
        end
        chk("ser_out", 32'(bus.ser_out), 32'(es));
        chk("bit_valid", 32'(bus.bit_valid), 32'(ev));
        chk("word_done", 32'(bus.word_done), 32'(ew));
        if (bus.bit_valid === 1'b1) cap = {cap[30:0], bus.ser_out};
    endtask

    initial begin
        int n;
        reset          = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.idle_level = 1'b0;
        cap            = '0;
        acc            = 1'b0;

        // reset state, with a word offered that must be refused
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h99;
        cyc();
        cyc();
        bus.data_valid = 1'b0;
        reset = 1'b1;

        // single word A5 on a low idle line
        cap = '0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hA5;
        cyc();
        bus.data_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) cyc();
`ifdef SEQ_SER_PARITY_EN
        chk("a5_stream", {23'd0, cap[8:0]}, {23'd0, 8'hA5, 1'b0});
`else
        chk("a5_stream", {24'd0, cap[7:0]}, 32'h0000_00A5);
`endif

        // F0 then 0F back to back, valid held high
        cap = '0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hF0;
        cyc();
        bus.data_in = 8'h0F;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cyc();
            n++;
        end
        chk("b2b_accept_cycles", 32'(n), 32'(W + int'(PAR)));
        bus.data_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) cyc();
`ifdef SEQ_SER_PARITY_EN
        chk("b2b_stream", {14'd0, cap[17:0]},
            {14'd0, 8'hF0, 1'b0, 8'h0F, 1'b0});
`else
        chk("b2b_stream", {16'd0, cap[15:0]}, 32'h0000_F00F);
`endif

        // 3C offered mid-word, held until the final bit cycle
        cap = '0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h81;
        cyc();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h3C;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            cyc();
            n++;
        end
        chk("hold_3c_wait", 32'(n), 32'(W - 3 + int'(PAR)));
        bus.data_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) cyc();
`ifdef SEQ_SER_PARITY_EN
        chk("hold_3c_stream", {23'd0, cap[8:0]}, {23'd0, 8'h3C, 1'b0});
`else
        chk("hold_3c_stream", {16'd0, cap[15:0]}, 32'h0000_813C);
`endif

        // reset in the middle of FF: partial word dropped
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        cyc();
        bus.data_valid = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // idle_level high with nothing to send
        bus.idle_level = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        bus.idle_level = 1'b0;

`ifdef SEQ_SER_PARITY_EN
        cap = '0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h07;
        cyc();
        bus.data_in = 8'h03;
        for (int i = 0; i < W + 1; i++) cyc();
        bus.data_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) cyc();
        chk("parity_07_03", {14'd0, cap[17:0]},
            {14'd0, 8'h07, 1'b1, 8'h03, 1'b0});
`endif

        // random traffic; the producer holds a word until it is taken
        acc = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!bus.data_valid || acc) begin
                bus.data_valid = ($urandom_range(0, 2) != 0);
                bus.data_in    = W'($urandom);
            end
            bus.idle_level = 1'($urandom);
            reset          = ($urandom_range(0, 39) != 0);
            cyc();
        end
        reset = 1'b1;
        bus.data_valid = 1'b0;
        for (int i = 0; i < W + 3; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per word, legal range 2..16.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 SHALL have port data_in, input, WIDTH: parallel word to serialize.
REQ-005 SHALL have port data_valid, input, 1: data_in is valid this cycle.
REQ-006 SHALL have port data_ready, output, 1: block accepts a word this cycle.
REQ-007 SHALL have port idle_level, input, 1: line value driven when no word is being sent.
REQ-008 SHALL have port ser_out, output, 1: serial bit stream; drives the seq_in port of the downstream pattern-detector selector.
REQ-009 SHALL have port bit_valid, output, 1: ser_out carries a data or parity bit this cycle.
REQ-010 SHALL have port word_done, output, 1: one-cycle pulse coinciding with the last bit of a word.

Function
REQ-011 SHALL accept a word on a rising edge where data_valid=1 and data_ready=1; data_in is captured into the shift register at that edge.
REQ-012 SHALL use FSM states IDLE, SHIFT and PARITY (PARITY present only per REQ-024).
REQ-013 SHALL transition IDLE->SHIFT on accept; SHIFT->IDLE after the last data bit if no new word is accepted; SHIFT->SHIFT (reload) if a word is accepted on the last-bit edge.
REQ-014 SHALL send data MSB first: bit WIDTH-1 appears on ser_out in the cycle after the accept edge; 1-cycle latency; one bit per clock.
REQ-015 SHALL count bits with a counter of ceil(log2(WIDTH)) bits that loads 0 on accept and increments each SHIFT cycle; it does not wrap while in SHIFT.
REQ-016 SHALL drive data_ready=1 in IDLE and in the final bit cycle of a word (the last data bit, or the PARITY cycle when REQ-024 applies), and 0 otherwise; data_ready is combinational from state and counter.
REQ-017 SHALL support gapless back-to-back words: an accept in the final bit cycle puts the next word's MSB on ser_out in the immediately following cycle, with bit_valid held at 1.
REQ-018 SHALL ignore data_in and leave the shift register unchanged whenever data_valid=1 and data_ready=0; the upstream holds the word until it is accepted.
REQ-019 SHALL register ser_out=idle_level and bit_valid=0 in every IDLE cycle; idle_level is sampled each cycle.
REQ-020 SHALL register word_done=1 only in the final bit cycle of each word.

Reset
REQ-021 SHALL, on a rising edge with reset=0, set state=IDLE, ser_out=0, bit_valid=0, word_done=0, bit counter=0 and shift register=0.
REQ-022 SHALL force data_ready=0 while reset=0; the first accept is possible on the first edge after reset returns to 1.
REQ-023 SHALL, on reset mid-word, discard the partial word; no word_done is issued for it.

Configuration
REQ-024 SHALL, when SEQ_SER_PARITY_EN is defined, append one even-parity bit (XOR of the WIDTH data bits) after the LSB in state PARITY, with bit_valid=1; word_done and data_ready move to the PARITY cycle.
REQ-025 SHALL, when SEQ_SER_PARITY_EN is undefined, omit the PARITY state and all parity logic; each word occupies exactly WIDTH cycles.

Structure
REQ-026 SHALL place the state enum typedef (IDLE/SHIFT/PARITY) and the default WIDTH constant in the shared package seq_pkg.
REQ-027 SHALL implement the bit counter as sub-module seq_bitcnt (inputs load and inc; output count; terminal-count flag).

Verification
REQ-028 SHALL cover: WIDTH=8, accept 8'hA5 while idle_level=0 -> ser_out=1,0,1,0,0,1,0,1 in the next 8 cycles, bit_valid=1 for 8 cycles, word_done on the 8th, then ser_out=0.
REQ-029 SHALL cover: 8'hF0 then 8'h0F with data_valid held high -> 16 consecutive bit_valid cycles carrying 1111000000001111, no gap.
REQ-030 SHALL cover: data_valid asserted with 8'h3C during bit 3 of a word -> data_ready=0 until the last-bit cycle, after which 8'h3C is sent gaplessly.
REQ-031 SHALL cover: reset=0 for one edge after bit 3 of 8'hFF -> ser_out=0, bit_valid=0 and no word_done next cycle; data_ready=1 after reset releases.
REQ-032 SHALL cover: with SEQ_SER_PARITY_EN defined, 8'h07 -> bits 00000111 followed by parity bit 1, word_done on the 9th cycle; 8'h03 -> parity bit 0.
REQ-033 SHALL cover: idle_level=1 with no valid input -> ser_out=1 and bit_valid=0 every cycle.
